// File: rtl/data_display_reader.sv
// data_display_reader
//
// Captures a 14-bit binary word and converts it to four BCD digits using a
// sequential double-dabble (one shift step per clock, 14 steps). The latched
// result is shown on a four-digit, common-anode seven-segment display. The
// display scan runs continuously and does not depend on the converter.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   value     binary word to convert (sampled when a conversion starts)
//   start     conversion request, honoured only while idle
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd/overflow are loaded
//   bcd       latched result, [3:0] ones ... [15:12] thousands
//   overflow  latched flag, captured value was above 9999
//   an        digit enables, active-low, an[0] = ones digit
//   seg       segments {g,f,e,d,c,b,a}, active-low
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; bcd/overflow hold the last result
// CONV  | one double-dabble step per cycle, 14 cycles, then load result

module data_display_reader #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int            RW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state;
    logic [13:0] shreg;
    logic [15:0] scratch;
    logic [3:0]  iter;
    logic        ov_cap;

    logic [15:0] adj;
    logic [15:0] scratch_nxt;
    logic [13:0] shreg_nxt;

    // One double-dabble step: correct each nibble, then shift the whole
    // {scratch, shreg} chain left. Bits leaving the thousands nibble are the
    // ten-thousands carry, which only the overflow flag cares about.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
        scratch_nxt = {adj[14:0], shreg[13]};
        shreg_nxt   = {shreg[12:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= 16'h0000;
            overflow <= 1'b0;
            shreg    <= '0;
            scratch  <= '0;
            iter     <= '0;
            ov_cap   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= value;
                        scratch <= '0;
                        iter    <= '0;
                        ov_cap  <= (value >= 14'd10000);
                        state   <= CONV;
                        busy    <= 1'b1;
                    end
                end
                CONV: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    iter    <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd      <= scratch_nxt;
                        overflow <= ov_cap;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [RW-1:0] rcnt;
    logic [1:0]    idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == RMAX) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    logic [3:0] digit;
    logic [6:0] pat;
    logic       lead_zero;

    always_comb begin
        an      = 4'b1111;
        an[idx] = 1'b0;

        digit = bcd[{idx, 2'b00} +: 4];

        // A digit is a leading zero when it and everything above it are zero;
        // the ones digit is always shown.
        case (idx)
            2'd1:    lead_zero = (bcd[15:4]  == 12'd0);
            2'd2:    lead_zero = (bcd[15:8]  == 8'd0);
            2'd3:    lead_zero = (bcd[15:12] == 4'd0);
            default: lead_zero = 1'b0;
        endcase

        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase

        if (overflow)
            seg = SEG_DASH;
        else if (BLANK_LEAD && lead_zero)
            seg = SEG_BLANK;
        else
            seg = pat;
    end

endmodule
